// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and filtered clock, odd-parity and
// framing checks, mid-frame watchdog, and a small output FIFO with valid/ready.
`timescale 1ns/1ps
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_ps2_clock,
    input  logic                          i_ps2_data,
    output logic [7:0]                    o_rx_data,
    output logic                          o_rx_valid,
    input  logic                          i_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_busy,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_timeout_err,
    output logic                          o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_CHECK} state_t;

    logic [1:0]            r_clk_sync, r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt, w_filt_next;
    logic                  r_f, w_f_next, w_fall, w_bit;

    state_t                r_state, w_state_next;
    logic [3:0]            r_bit_cnt, w_bit_cnt_next;
    logic [9:0]            r_shift, w_shift_next;
    logic [WW-1:0]         r_wdog, w_wdog_next;
    logic                  w_parity_err_next, w_frame_err_next, w_timeout_next, w_push_req;

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_pop, w_push, w_overflow;

    logic                  r_busy, r_parity_err, r_frame_err, r_timeout_err, r_overflow;

    // Filtered clock only moves once the whole window agrees.
    always_comb begin
        w_filt_next = {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
        w_f_next    = r_f;
        if (&w_filt_next)
            w_f_next = 1'b1;
        else if (~|w_filt_next)
            w_f_next = 1'b0;
        w_fall = r_f & ~w_f_next;
        w_bit  = r_dat_sync[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b00;
            r_dat_sync <= 2'b00;
            r_filt     <= '0;
            r_f        <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clock};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_filt     <= w_filt_next;
            r_f        <= w_f_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_wdog_next       = r_wdog;
        w_parity_err_next = 1'b0;
        w_frame_err_next  = 1'b0;
        w_timeout_next    = 1'b0;
        w_push_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (!w_bit) begin
                        w_state_next   = S_RX;
                        w_bit_cnt_next = 4'd0;
                        w_wdog_next    = '0;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
            end
            S_RX: begin
                if (w_fall) begin
                    w_shift_next   = {w_bit, r_shift[9:1]};
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    w_wdog_next    = '0;
                    if (r_bit_cnt == 4'd9)
                        w_state_next = S_CHECK;
                end else if (r_wdog == WDOG_LAST) begin
                    w_state_next   = S_IDLE;
                    w_timeout_next = 1'b1;
                end else begin
                    w_wdog_next = r_wdog + 1'b1;
                end
            end
            S_CHECK: begin
                w_state_next = S_IDLE;
                // Parity wins over stop so a frame raises at most one error.
                if (^r_shift[8:0] == 1'b0)
                    w_parity_err_next = 1'b1;
                else if (!r_shift[9])
                    w_frame_err_next = 1'b1;
                else
                    w_push_req = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 4'd0;
            r_shift       <= 10'd0;
            r_wdog        <= '0;
            r_busy        <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_shift       <= w_shift_next;
            r_wdog        <= w_wdog_next;
            r_busy        <= (w_state_next != S_IDLE);
            r_parity_err  <= w_parity_err_next;
            r_frame_err   <= w_frame_err_next;
            r_timeout_err <= w_timeout_next;
            r_overflow    <= w_overflow;
        end
    end

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_pop      = (r_count != '0) & i_rx_ready;
    assign w_push     = w_push_req & ((r_count != DEPTH_C) | w_pop);
    assign w_overflow = w_push_req & ~w_push;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_shift[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rx_valid    = (r_count != '0);
    assign o_rx_data     = o_rx_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign o_fifo_count  = r_count;
    assign o_busy        = r_busy;
    assign o_parity_err  = r_parity_err;
    assign o_frame_err   = r_frame_err;
    assign o_timeout_err = r_timeout_err;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and randomized frames checked against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int FD   = 4;
    localparam int HALF = 20;

    logic       clk = 1'b0, reset = 1'b1;
    logic       ps2_clock = 1'b1, ps2_data = 1'b1, rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, busy, parity_err, frame_err, timeout_err, overflow;
    logic [2:0] fifo_count;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset),
        .i_ps2_clock(ps2_clock), .i_ps2_data(ps2_data),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
        .o_fifo_count(fifo_count), .o_busy(busy),
        .o_parity_err(parity_err), .o_frame_err(frame_err),
        .o_timeout_err(timeout_err), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int par_cnt = 0, frm_cnt = 0, tmo_cnt = 0, ovf_cnt = 0;
    int exp_par = 0, exp_frm = 0, exp_tmo = 0, exp_ovf = 0;
    bit busy_seen = 0, measure_l = 0;
    int l_lat = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Observer: accepted bytes and error pulses, counted per high cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            par_cnt += int'(parity_err);
            frm_cnt += int'(frame_err);
            tmo_cnt += int'(timeout_err);
            ovf_cnt += int'(overflow);
            if (busy) busy_seen = 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_parity"}, par_cnt, exp_par);
        check({tag, "_frame"}, frm_cnt, exp_frm);
        check({tag, "_timeout"}, tmo_cnt, exp_tmo);
        check({tag, "_overflow"}, ovf_cnt, exp_ovf);
    endtask

    task automatic check_queue(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // One PS/2 bit: data set while clock high, then a low phase.
    task automatic send_bit(input logic b, input logic is_stop, input logic do_pulse);
        ps2_data = b;
        tick(HALF);
        ps2_clock = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            tick(1);
            if (is_stop && measure_l && l_lat == 0 && !busy) l_lat = k;
            if (is_stop && do_pulse) begin
                if (k == l_lat - 1) rx_ready = 1'b1;
                else if (k == l_lat) rx_ready = 1'b0;
            end
        end
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input logic do_pulse);
        logic p;
        p = (~^d) ^ par_flip;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, 1'b0);
        send_bit(p, 1'b0, 1'b0);
        send_bit(stop, 1'b1, do_pulse);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    // Frame-level outcome with the consumer ready.
    task automatic model_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        if (par_flip) exp_par++;
        else if (!stop) exp_frm++;
        else exp_q.push_back(d);
    endtask

    task automatic frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_frame(d, par_flip, stop, 1'b0);
        model_frame(d, par_flip, stop);
    endtask

    initial begin
        logic [7:0] d;
        int kind;

        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {parity_err, frame_err, timeout_err, overflow}, 4'b0000);
        reset = 1'b0;
        tick(10);

        measure_l = 1;
        frame(8'h1C, 0, 1);
        measure_l = 0;
        check("stop_to_busy_low_in_range", (l_lat >= FL + 2 && l_lat <= FL + 4), 1);
        frame(8'hF0, 0, 1);
        tick(5);
        check_queue("good");
        check_errs("good");

        frame(8'h1C, 1, 1);
        check("parity_count", fifo_count, 0);
        frame(8'h1C, 0, 1);
        check_queue("after_parity");
        check_errs("parity");

        frame(8'h55, 0, 0);
        busy_seen = 0;
        ps2_data = 1'b1; tick(HALF);
        ps2_clock = 1'b0; tick(HALF);
        ps2_clock = 1'b1; tick(HALF);
        exp_frm++;
        check_errs("framing");
        check("lone_fall_busy", busy_seen, 0);
        check_queue("framing");

        busy_seen = 0;
        ps2_data = 1'b0; tick(HALF);
        ps2_clock = 1'b0; tick(FL - 1);
        ps2_clock = 1'b1; tick(HALF);
        ps2_data = 1'b1; tick(HALF);
        ps2_clock = 1'b0; tick(FL - 1);
        ps2_clock = 1'b1; tick(HALF);
        check("glitch_busy", busy_seen, 0);
        check_errs("glitch");

        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1, 0);
        exp_ovf++;
        check("ovf_count", fifo_count, 4);
        check("ovf_head", rx_data, 8'h01);
        check_errs("overflow");
        rx_ready = 1'b1;
        tick(10);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        check_queue("drain");
        check("drain_valid", rx_valid, 0);

        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 0, 1, 0);
        send_frame(8'hA4, 0, 1, 1);
        check("simul_count", fifo_count, 4);
        check_errs("simul");
        exp_q.push_back(8'hA0);
        rx_ready = 1'b1;
        tick(10);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        check_queue("simul");

        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 4);
            case (kind)
                2:       frame(d, 1, 1);
                3:       frame(d, 0, 0);
                4:       frame(d, 1, 0);
                default: frame(d, 0, 1);
            endcase
        end
        tick(5);
        check_queue("random");
        check_errs("random");

        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        ps2_data = 1'b1;
        tick(TO - 60);
        check("wdog_busy_before", busy, 1);
        check("wdog_tmo_before", tmo_cnt, exp_tmo);
        tick(60);
        exp_tmo++;
        check("wdog_busy_after", busy, 0);
        check_errs("timeout");
        frame(8'h3C, 0, 1);
        check_queue("after_timeout");

        rx_ready = 1'b0;
        send_frame(8'h77, 0, 1, 0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        ps2_data = 1'b0; tick(HALF);
        ps2_clock = 1'b0; tick(HALF / 2);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", rx_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_data", rx_data, 8'h00);
        tick(3);
        ps2_clock = 1'b1; ps2_data = 1'b1;
        reset = 1'b0;
        tick(HALF);
        rx_ready = 1'b1;
        frame(8'h5A, 0, 1);
        tick(20);
        check_queue("after_reset");
        check_errs("after_reset");
        check("end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with input synchronisation, configurable glitch filter, odd-parity and framing checks, an inactivity watchdog and an output FIFO with valid/ready handshake. It sits between the PS/2 connector pins and the keyboard scancode decoder. It replaces the fixed 8-tap, unchecked, tick-only receiver. Frames are buffered so the consumer can stall without losing scancodes.

## Interface
- FILTER_LEN, 8: ps2_clock filter taps (≥2); filtered level changes only after FILTER_LEN equal synced samples.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered falling edge, while mid-frame, before the frame is aborted (≥2).
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, ≥2.

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; clears all state.
- ps2_clock  input  1  raw PS/2 clock pin (asynchronous).
- ps2_data  input  1  raw PS/2 data pin (asynchronous).
- rx_data  output  8  FIFO head byte; valid only when rx_valid=1.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts the head when rx_valid&rx_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
- busy  output  1  receiver FSM not in IDLE.
- parity_err  output  1  one-cycle pulse: parity check failed, byte dropped.
- frame_err  output  1  one-cycle pulse: start bit 1 or stop bit 0, byte dropped.
- timeout_err  output  1  one-cycle pulse: frame aborted by watchdog.
- overflow  output  1  one-cycle pulse: good byte dropped because FIFO full.

## Operation
- Both pins pass a 2-flop synchroniser. Synced clock feeds a FILTER_LEN shift register. Filtered value f becomes 1 on all-ones, 0 on all-zeros, else holds. f resets to 0.
- fall = f_reg & ~f_next. Synced ps2_data is sampled in the fall cycle.
- FSM states are IDLE, RX and CHECK.
  - IDLE: on fall with data=0, go to RX with bit count 0 and clear the watchdog. On fall with data=1, pulse frame_err and stay in IDLE.
  - RX: each fall right-shifts data into a 10-bit register (8 data bits LSB-first, then parity, then stop) and increments the count. After the 10th fall, go to CHECK.
  - CHECK: one cycle, then return to IDLE.
    - If the XOR of the 8 data bits and the parity bit is not 1, pulse parity_err.
    - Else if stop=0, pulse frame_err.
    - Else push the byte, or pulse overflow if the push is refused.
    - Parity is evaluated before stop; only one error pulse is raised per frame.
- Watchdog, in RX only:
  - The counter clears on every fall.
  - After TIMEOUT_CYCLES consecutive cycles without a fall, go to IDLE, pulse timeout_err and discard the partial frame.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Pop when rx_valid & rx_ready.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged.
  - Pop when empty is ignored.
- Reset mid-frame: all state clears immediately and the partial frame is lost. A frame already in progress on the wire may then be seen as a start-bit error or a timeout.

## Timing
- Reset values:
  - rx_valid=0, rx_data=8'h00, fifo_count=0, busy=0.
  - All error pulses 0; f=0, so the first fall needs a filtered high first.
- A pin falling edge produces fall 2+FILTER_LEN cycles later, ±1 for synchroniser phase.
- Stop-bit fall cycle t:
  - CHECK occurs at t+1.
  - FIFO write and error/overflow pulses are registered, visible at t+2.
  - rx_valid rises at t+2 if the FIFO was empty.
- rx_data is the combinational read of the head entry. The next entry appears the cycle after a pop.
- All status outputs are registered. Pulses are exactly one clk wide.
- busy rises the cycle after the start fall. It falls in the cycle CHECK exits, or in the timeout cycle.

## Test plan
- Good frames: send 0x1C (parity 0) then 0xF0 (parity 1), with rx_ready=1 → rx_valid pulses twice, rx_data 0x1C then 0xF0, no error pulses.
- Parity error: send 0x1C with parity=1 → parity_err one pulse, fifo_count stays 0. A following 0x1C is received correctly.
- Framing: send stop=0 → frame_err, no push. Send a lone fall with data=1 → frame_err, busy stays 0.
- Overflow/order: FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 → fifo_count=4, overflow pulses once on 0x05. Drain with rx_ready=1 → 0x01..0x04 in order, then rx_valid=0.
- Simultaneous: FIFO full, pulse rx_ready in the push cycle → byte accepted, no overflow, fifo_count stays 4.
- Glitch/timeout/reset:
  - A FILTER_LEN-1-cycle low glitch on ps2_clock → ignored.
  - Stop clocking after 5 bits → timeout_err after TIMEOUT_CYCLES, busy=0, next frame correct.
  - Assert reset mid-frame → all outputs return to reset values within the same cycle.
